reg_file_mp: RTL and testbench

Parametrised multi-port register file, the next-generation register file for the processor datapath. It generalises width, depth, read-port count and write-port count. It adds asynchronous reset, optional same-cycle write-to-read bypass, a per-register pending-write scoreboard for multicycle units, and write-collision detection. Decode reads it, and writeback and multicycle units write it.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_scoreboard.sv | 34 +++
 rtl/reg_file_mp.sv | 107 ++++++++++
 tb/tb_reg_file_mp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and the write-port priority select used by
// the register file storage path and its read bypass.
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_PORTS  = 16;

    // Highest set bit of a port match vector, or -1 when no port matches.
    function automatic int hi_match(input logic [MAX_PORTS-1:0] m);
        int s;
        s = -1;
        for (int i = 0; i < MAX_PORTS; i++)
            if (m[i]) s = i;
        return s;
    endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register pending-write bits; a new busySet
// supersedes a retiring write to the same register at the same edge.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set,
    input  logic [ADDR_W-1:0]    i_set_addr,
    input  logic [2**ADDR_W-1:0] i_clear,
    output logic [2**ADDR_W-1:0] o_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (i_set && i_set_addr == ADDR_W'(a) && !(ZERO_REG != 0 && a == 0))
                    r_busy[a] <= 1'b1;
                else if (i_clear[a])
                    r_busy[a] <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with optional write
// bypass, pending-write scoreboard and registered write-collision flag.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
)(
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_WRITE-1:0]          writeEnable,
    input  logic [NUM_WRITE*ADDR_W-1:0]   writeAddress,
    input  logic [NUM_WRITE*DATA_W-1:0]   writeData,
    input  logic [NUM_READ*ADDR_W-1:0]    readAddress,
    output logic [NUM_READ*DATA_W-1:0]    readData,
    output logic [NUM_READ-1:0]           readBusy,
    input  logic                          busySet,
    input  logic [ADDR_W-1:0]             busyAddress,
    output logic [2**ADDR_W-1:0]          busyVector,
    output logic                          writeConflict
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_conf;
    logic [DEPTH-1:0]  w_we;
    logic [DATA_W-1:0] w_wd [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_conf;

    // Enabled write ports targeting address a; writes to a hardwired zero register never match.
    function automatic logic [MAX_PORTS-1:0] match_vec(input logic [ADDR_W-1:0] a);
        logic [MAX_PORTS-1:0] m;
        m = '0;
        for (int w = 0; w < NUM_WRITE; w++)
            m[w] = writeEnable[w] && writeAddress[w*ADDR_W +: ADDR_W] == a && !(ZERO_REG != 0 && a == '0);
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] port_data(input int s);
        return writeData[(s < 0 ? 0 : s)*DATA_W +: DATA_W];
    endfunction

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            w_we[a] = hi_match(match_vec(ADDR_W'(a))) >= 0;
            w_wd[a] = port_data(hi_match(match_vec(ADDR_W'(a))));
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int i = 0; i < NUM_WRITE; i++)
            for (int j = i + 1; j < NUM_WRITE; j++)
                if (writeEnable[i] && writeEnable[j]
                    && writeAddress[i*ADDR_W +: ADDR_W] == writeAddress[j*ADDR_W +: ADDR_W]
                    && !(ZERO_REG != 0 && writeAddress[i*ADDR_W +: ADDR_W] == '0))
                    w_conf = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
            r_conf <= 1'b0;
        end else begin
            for (int a = 0; a < DEPTH; a++)
                if (w_we[a]) r_mem[a] <= w_wd[a];
            r_conf <= w_conf;
        end
    end

    // Bypass is held off during reset so reads return zero while RST_N is low.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            logic [ADDR_W-1:0] ra;
            int                s;
            logic              byp;
            ra  = readAddress[r*ADDR_W +: ADDR_W];
            s   = hi_match(match_vec(ra));
            byp = BYPASS != 0 && s >= 0 && RST_N;
            readData[r*DATA_W +: DATA_W] = byp ? port_data(s)
                                         : (ZERO_REG != 0 && ra == '0) ? '0 : r_mem[ra];
            readBusy[r] = w_busy[ra] && !(byp && !(busySet && busyAddress == ra));
        end
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_set      (busySet),
        .i_set_addr (busyAddress),
        .i_clear    (w_we),
        .o_busy     (w_busy)
    );

    assign busyVector    = w_busy;
    assign writeConflict = r_conf;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random and directed stimulus on a bypassing and a
// non-bypassing instance, checked every cycle against an array model.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int D  = 32;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [NW-1:0]   we = '0;
    logic [NW*AW-1:0] wa = '0;
    logic [NW*DW-1:0] wd = '0;
    logic [NR*AW-1:0] ra = '0;
    logic            bs = 1'b0;
    logic [AW-1:0]   ba = '0;

    logic [NR*DW-1:0] rd1, rd0;
    logic [NR-1:0]    rb1, rb0;
    logic [D-1:0]     bv1, bv0;
    logic             wc1, wc0;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_mem [D];
    logic [D-1:0]  m_busy;
    logic          m_conf;
    int            cnt [D];

    reg_file_mp #(.BYPASS(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .writeEnable(we), .writeAddress(wa), .writeData(wd),
        .readAddress(ra), .readData(rd1), .readBusy(rb1), .busySet(bs), .busyAddress(ba),
        .busyVector(bv1), .writeConflict(wc1)
    );

    reg_file_mp #(.BYPASS(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .writeEnable(we), .writeAddress(wa), .writeData(wd),
        .readAddress(ra), .readData(rd0), .readBusy(rb0), .busySet(bs), .busyAddress(ba),
        .busyVector(bv0), .writeConflict(wc0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // Reference model: ports applied in ascending order so the last one wins.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < D; i++) m_mem[i] = '0;
            m_busy = '0;
            m_conf = 1'b0;
        end else begin
            for (int i = 0; i < D; i++) cnt[i] = 0;
            for (int w = 0; w < NW; w++)
                if (we[w] && wa[w*AW +: AW] != 0) cnt[wa[w*AW +: AW]]++;
            m_conf = 1'b0;
            for (int i = 0; i < D; i++) if (cnt[i] >= 2) m_conf = 1'b1;
            for (int w = 0; w < NW; w++)
                if (we[w]) begin
                    m_busy[wa[w*AW +: AW]] = 1'b0;
                    if (wa[w*AW +: AW] != 0) m_mem[wa[w*AW +: AW]] = wd[w*DW +: DW];
                end
            if (bs && ba != 0) m_busy[ba] = 1'b1;
        end
    end

    function automatic bit hit(input int r);
        bit h = 0;
        for (int w = 0; w < NW; w++)
            if (we[w] && wa[w*AW +: AW] == ra[r*AW +: AW] && ra[r*AW +: AW] != 0) h = 1;
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int r, input bit byp);
        logic [AW-1:0] a = ra[r*AW +: AW];
        logic [DW-1:0] v = (a == 0) ? '0 : m_mem[a];
        if (byp && RST_N)
            for (int w = 0; w < NW; w++)
                if (we[w] && wa[w*AW +: AW] == a && a != 0) v = wd[w*DW +: DW];
        return RST_N ? v : '0;
    endfunction

    function automatic logic exp_rb(input int r, input bit byp);
        logic [AW-1:0] a = ra[r*AW +: AW];
        return m_busy[a] && !(byp && hit(r) && RST_N && !(bs && ba == a));
    endfunction

    always @(negedge CLK) begin
        for (int r = 0; r < NR; r++) begin
            chk("rd_byp", rd1[r*DW +: DW], exp_rd(r, 1));
            chk("rd_nobyp", rd0[r*DW +: DW], exp_rd(r, 0));
            chk("rb_byp", rb1[r], exp_rb(r, 1));
            chk("rb_nobyp", rb0[r], exp_rb(r, 0));
        end
        chk("bv_byp", bv1, m_busy);
        chk("bv_nobyp", bv0, m_busy);
        chk("wc_byp", wc1, m_conf);
        chk("wc_nobyp", wc0, m_conf);
    end

    task automatic drive(input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic s,
                         input logic [4:0] sa, input logic [4:0] r0, input logic [4:0] r1);
        we = e;
        wa = {a1, a0};
        wd = {d1, d0};
        bs = s;
        ba = sa;
        ra = {r1, r0};
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
    endtask

    initial begin
        #12 RST_N = 1'b1;
        step();
        // Write/read and bypass on reg 1
        drive(2'b01, 5'd1, 32'h0000_0011, 5'd9, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1);
        #1;
        chk("wr_same_cycle_old", rd0[DW-1:0], 32'h0);
        chk("byp_port0", rd1[DW-1:0], 32'h0000_0011);
        chk("byp_port1", rd1[2*DW-1:DW], 32'h0000_0011);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1);
        #1;
        chk("wr_next_cycle", rd0[DW-1:0], 32'h0000_0011);
        chk("model_r1", m_mem[1], 32'h0000_0011);
        // Zero register
        drive(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("zero_byp", rd1[DW-1:0], 32'h0);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("zero_read", rd0[DW-1:0], 32'h0);
        chk("zero_busy", bv1[0], 1'b0);
        // Collision on reg 3
        drive(2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 1'b0, 5'd0, 5'd3, 5'd3);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        #1;
        chk("coll_value", rd0[DW-1:0], 32'hB);
        chk("coll_flag", wc1, 1'b1);
        chk("model_r3", m_mem[3], 32'hB);
        step();
        chk("coll_flag_drop", wc1, 1'b0);
        // Scoreboard on reg 7
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
        step();
        drive(2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
        #1;
        chk("sb_set", bv1[7], 1'b1);
        chk("sb_readbusy_setwin", rb1[0], 1'b1);
        step();
        chk("sb_set_wins", bv1[7], 1'b1);
        drive(2'b01, 5'd7, 32'h78, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        chk("sb_byp_clear", rb1[0], 1'b0);
        chk("sb_nobyp_busy", rb0[0], 1'b1);
        step();
        chk("sb_cleared", bv1[7], 1'b0);
        rand_cycles(300);
        // Asynchronous reset mid-cycle
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd5);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        chk("pre_rst_r5", rd0[DW-1:0], 32'hDEAD_BEEF);
        RST_N = 1'b0;
        #1;
        chk("rst_r5", rd1[DW-1:0], 32'h0);
        chk("rst_r5_nobyp", rd0[DW-1:0], 32'h0);
        chk("rst_bv", bv1, 32'h0);
        chk("rst_wc", wc1, 1'b0);
        step();
        step();
        #1 RST_N = 1'b1;
        step();
        rand_cycles(300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
